// File: rtl/fpga_config_seq.sv
// Configuration sequencer for the main board FPGA: pulses PROG_B, waits for INIT_B/DONE with timeouts and retries.
// Optional build macro FPGA_CONFIG_AUTOBOOT_EN starts one sequence automatically after reset.
module fpga_config_seq #(
  parameter logic [1:0] MODE     = 2'b11,
  parameter int         PROG_LEN = 64,
  parameter int         INIT_TMO = 4096,
  parameter int         DONE_TMO = 1048576,
  parameter int         RETRIES  = 2,
  parameter int         CNT_W    = 21
) (
  input  logic       CLK,
  input  logic       CRST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       INIT,
  input  logic       DONE,
  output logic       PROG,
  output logic [1:0] M,
  output logic       BUSY,
  output logic       CONFIGURED,
  output logic [7:0] STATUS,
  output logic [2:0] DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PULSE     = 3'd1,
    S_WAIT_INIT = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RETRY     = 3'd4,
    S_CONFIG    = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] PROG_LIM  = CNT_W'(PROG_LEN - 1);
  localparam logic [CNT_W-1:0] INIT_LIM  = CNT_W'(INIT_TMO - 1);
  localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(DONE_TMO - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic [1:0]       attempt_q, attempt_d;
  logic             fail_q, fail_d;
  logic             ito_q, ito_d;
  logic             dto_q, dto_d;
  logic             crc_q, crc_d;
  logic [1:0]       init_sync_q, done_sync_q;
  logic             init_s, done_s;
  logic             prog_q, busy_q, configured_q;
  logic [1:0]       m_q;
  logic [7:0]       status_q;
  logic             start_req, go;

`ifdef FPGA_CONFIG_AUTOBOOT_EN
  logic boot_q;
  assign start_req = START | boot_q;
`else
  assign start_req = START;
`endif

  assign init_s    = init_sync_q[1];
  assign done_s    = done_sync_q[1];
  // Saturating so a timer left running can never wrap back under a limit.
  assign timer_inc = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    attempt_d = attempt_q;
    fail_d    = fail_q;
    ito_d     = ito_q;
    dto_d     = dto_q;
    crc_d     = crc_q;
    go        = 1'b0;
    case (state_q)
      S_IDLE, S_FAIL: go = start_req;
      S_PULSE: begin
        if (timer_q == PROG_LIM) begin
          state_d = S_WAIT_INIT;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_INIT: begin
        if (init_s) begin
          state_d = S_WAIT_DONE;
          timer_d = '0;
        end else if (timer_q == INIT_LIM) begin
          ito_d   = 1'b1;
          state_d = S_RETRY;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_DONE: begin
        if (done_s) begin
          state_d = S_CONFIG;
        end else if (!init_s) begin
          crc_d   = 1'b1;
          state_d = S_RETRY;
        end else if (timer_q == DONE_LIM) begin
          dto_d   = 1'b1;
          state_d = S_RETRY;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RETRY: begin
        if (attempt_q < RETRY_LIM) begin
          attempt_d = attempt_q + 2'd1;
          timer_d   = '0;
          state_d   = S_PULSE;
        end else begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end
      end
      S_CONFIG: begin
        if (!done_s) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          go = start_req;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go) begin
      state_d   = S_PULSE;
      timer_d   = '0;
      attempt_d = 2'd0;
      fail_d    = 1'b0;
      ito_d     = 1'b0;
      dto_d     = 1'b0;
      crc_d     = 1'b0;
    end
    // Abort keeps the sticky error bits so software can still read why it stopped.
    if (ABORT) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      attempt_d = 2'd0;
    end
  end

  always_ff @(posedge CLK or posedge CRST) begin
    if (CRST) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      attempt_q    <= 2'd0;
      fail_q       <= 1'b0;
      ito_q        <= 1'b0;
      dto_q        <= 1'b0;
      crc_q        <= 1'b0;
      init_sync_q  <= 2'b00;
      done_sync_q  <= 2'b00;
      prog_q       <= 1'b1;
      m_q          <= MODE;
      busy_q       <= 1'b0;
      configured_q <= 1'b0;
      status_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      attempt_q    <= attempt_d;
      fail_q       <= fail_d;
      ito_q        <= ito_d;
      dto_q        <= dto_d;
      crc_q        <= crc_d;
      init_sync_q  <= {init_sync_q[0], INIT};
      done_sync_q  <= {done_sync_q[0], DONE};
      prog_q       <= (state_d != S_PULSE);
      m_q          <= MODE;
      busy_q       <= (state_d inside {S_PULSE, S_WAIT_INIT, S_WAIT_DONE, S_RETRY});
      configured_q <= (state_d == S_CONFIG);
      status_q     <= {attempt_q, crc_q, dto_q, ito_q, fail_q, configured_q, busy_q};
    end
  end

`ifdef FPGA_CONFIG_AUTOBOOT_EN
  always_ff @(posedge CLK or posedge CRST) begin
    if (CRST) boot_q <= 1'b1;
    else      boot_q <= 1'b0;
  end
`endif

  assign PROG       = prog_q;
  assign M          = m_q;
  assign BUSY       = busy_q;
  assign CONFIGURED = configured_q;
  assign STATUS     = status_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_fpga_config_seq.sv
// Self-checking bench for fpga_config_seq: FPGA INIT/DONE behaviour is scripted, PROG pulses are scoreboarded.
module tb_fpga_config_seq;

  localparam int PROG_LEN = 8;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_CONFIG = 3'd5, ST_FAIL = 3'd6;

  logic       CLK = 1'b0;
  logic       CRST = 1'b1;
  logic       START = 1'b0, ABORT = 1'b0, INIT = 1'b0, DONE = 1'b0;
  logic       PROG, BUSY, CONFIGURED;
  logic [1:0] M;
  logic [7:0] STATUS;
  logic [2:0] DBG_STATE;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int snap;
  logic [31:0] exp_q[$];

  fpga_config_seq #(
    .MODE(2'b11), .PROG_LEN(PROG_LEN), .INIT_TMO(16), .DONE_TMO(256),
    .RETRIES(2), .CNT_W(21)
  ) dut (
    .CLK(CLK), .CRST(CRST), .START(START), .ABORT(ABORT), .INIT(INIT), .DONE(DONE),
    .PROG(PROG), .M(M), .BUSY(BUSY), .CONFIGURED(CONFIGURED), .STATUS(STATUS),
    .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick(1);
    START = 1'b0;
  endtask

  task automatic wait_prog(input logic v, input int budget, input string tag);
    int k = 0;
    while (PROG !== v && k < budget) begin
      tick(1);
      k++;
    end
    if (PROG !== v) chk(tag, PROG, v);
  endtask

  task automatic wait_busy_low(input int budget, input string tag);
    int k = 0;
    while (BUSY !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    if (BUSY !== 1'b0) chk(tag, BUSY, 0);
  endtask

  task automatic do_reset();
    CRST = 1'b1; START = 1'b0; ABORT = 1'b0; INIT = 1'b0; DONE = 1'b0;
    tick(3);
    CRST = 1'b0;
    tick(1);
  endtask

  // One attempt where the FPGA answers normally: INIT 10 cycles after PROG rises, DONE 100 later.
  task automatic good_attempt(input string tag);
    wait_prog(1'b0, 5, {tag, "_prog_fall"});
    wait_prog(1'b1, PROG_LEN + 4, {tag, "_prog_rise"});
    tick(10);
    INIT = 1'b1;
    tick(100);
    DONE = 1'b1;
    tick(3);
  endtask

  // PROG pulse monitor: every completed low pulse is matched against the expected queue.
  initial begin
    int low_cnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (CRST) begin
        low_cnt = 0;
      end else if (PROG === 1'b0) begin
        low_cnt++;
      end else if (low_cnt > 0) begin
        pulses++;
        if (exp_q.size() == 0) chk("pulse_unexpected", low_cnt, 0);
        else                   chk("prog_width", low_cnt, exp_q.pop_front());
        low_cnt = 0;
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_prog", PROG, 1);
    chk("rst_m", M, 2'b11);
    chk("rst_busy", BUSY, 0);
    chk("rst_conf", CONFIGURED, 0);
    chk("rst_status", STATUS, 8'h00);
    chk("rst_state", DBG_STATE, ST_IDLE);
    CRST = 1'b0;
    tick(6);

    // Nominal sequence
    exp_q.push_back(PROG_LEN);
    pulse_start();
    chk("nom_busy", BUSY, 1);
    good_attempt("nom");
    chk("nom_conf", CONFIGURED, 1);
    tick(2);
    chk("nom_status", STATUS, 8'h02);
    chk("nom_state", DBG_STATE, ST_CONFIG);
    chk("nom_q_empty", exp_q.size(), 0);

    // INIT never rises: three attempts then FAIL; a START while busy must not restart
    do_reset();
    repeat (3) exp_q.push_back(PROG_LEN);
    pulse_start();
    wait_prog(1'b1, PROG_LEN + 4, "ito_prog_rise");
    tick(3);
    pulse_start();
    tick(2);
    wait_busy_low(200, "ito_busy_low");
    tick(2);
    chk("ito_status", STATUS, 8'h8C);
    chk("ito_busy", BUSY, 0);
    chk("ito_state", DBG_STATE, ST_FAIL);
    chk("ito_q_empty", exp_q.size(), 0);

    // CRC error on attempt 0, success on attempt 1
    do_reset();
    repeat (2) exp_q.push_back(PROG_LEN);
    pulse_start();
    wait_prog(1'b1, PROG_LEN + 4, "crc_prog_rise");
    tick(10);
    INIT = 1'b1;
    tick(30);
    INIT = 1'b0;
    wait_prog(1'b0, 10, "crc_prog_refall");
    good_attempt("crc");
    chk("crc_conf", CONFIGURED, 1);
    tick(2);
    chk("crc_status", STATUS, 8'h62);
    chk("crc_q_empty", exp_q.size(), 0);

    // ABORT and START together in WAIT_DONE
    do_reset();
    exp_q.push_back(PROG_LEN);
    pulse_start();
    wait_prog(1'b1, PROG_LEN + 4, "abt_prog_rise");
    tick(10);
    INIT = 1'b1;
    tick(10);
    ABORT = 1'b1; START = 1'b1;
    tick(1);
    ABORT = 1'b0; START = 1'b0; INIT = 1'b0;
    chk("abt_state", DBG_STATE, ST_IDLE);
    chk("abt_prog", PROG, 1);
    chk("abt_busy", BUSY, 0);
    snap = pulses;
    tick(30);
    chk("abt_no_pulse", pulses, snap);
    chk("abt_status", STATUS, 8'h00);

    // DONE lost while configured
    exp_q.push_back(PROG_LEN);
    pulse_start();
    good_attempt("dl");
    chk("dl_conf", CONFIGURED, 1);
    DONE = 1'b0;
    tick(2);
    chk("dl_conf_hold", CONFIGURED, 1);
    tick(1);
    chk("dl_conf_clr", CONFIGURED, 0);
    tick(2);
    chk("dl_status", STATUS, 8'h04);
    chk("dl_state", DBG_STATE, ST_FAIL);

    // Asynchronous reset in the middle of PULSE
    INIT = 1'b0;
    pulse_start();
    tick(2);
    chk("ar_prog_low", PROG, 0);
    #3;
    CRST = 1'b1;
    #1;
    chk("ar_prog_async", PROG, 1);
    chk("ar_busy_async", BUSY, 0);
    tick(2);
    CRST = 1'b0;
    snap = pulses;
    tick(20);
    chk("ar_prog_idle", PROG, 1);
    chk("ar_state", DBG_STATE, ST_IDLE);
    chk("ar_no_pulse", pulses, snap);
    chk("ar_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
